raw_xtor_sweep_ctrl: RTL

//   Sequences threshold sweeps over the raw-transistor test structures that share the ua[] analog pins.
//   - Selects one enabled device-under-test (DUT) at a time via the analog switch bank.
//   - Ramps a digital gate-drive code and samples the on-chip comparator after a settle delay.
//   - Reports the first code at which the comparator trips.
//   - Sits between the tt_um_sakemi_raw_transistors top and the switch/DAC/comparator analog macros.

---
 rtl/raw_xtor_pkg.sv | 35 +++
 rtl/raw_xtor_cmp_sync.sv | 21 ++
 rtl/raw_xtor_sweep_ctrl.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/raw_xtor_pkg.sv
// Shared definitions for the raw-transistor threshold sweep controller.
// The optional 3-sample majority vote is enabled by defining RAW_XTOR_MAJ3_EN.
package raw_xtor_pkg;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_SELECT = 3'd1;
    localparam logic [2:0] S_SETTLE = 3'd2;
    localparam logic [2:0] S_SAMPLE = 3'd3;
    localparam logic [2:0] S_REPORT = 3'd4;
    localparam logic [2:0] S_FINISH = 3'd5;

    typedef enum logic [2:0] {
        ST_IDLE   = S_IDLE,
        ST_SELECT = S_SELECT,
        ST_SETTLE = S_SETTLE,
        ST_SAMPLE = S_SAMPLE,
        ST_REPORT = S_REPORT,
        ST_FINISH = S_FINISH
    } state_t;

    // Index width for n devices, never narrower than one bit.
    function automatic int sel_width(input int n);
        int w;
        w = 0;
        for (int i = 0; i < 32; i++) begin
            if ((1 << w) < n) w++;
        end
        return (w < 1) ? 1 : w;
    endfunction

    function automatic int max_code(input int w);
        return (1 << w) - 1;
    endfunction

endpackage

// File: rtl/raw_xtor_cmp_sync.sv
// Two-flop synchronizer for the asynchronous comparator output.
module raw_xtor_cmp_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/raw_xtor_sweep_ctrl.sv
// Threshold sweep sequencer: one enabled DUT at a time, ramp gate code, report first trip.
// Define RAW_XTOR_MAJ3_EN for a 3-cycle SAMPLE with majority vote on the comparator.
module raw_xtor_sweep_ctrl
    import raw_xtor_pkg::*;
#(
    parameter  int NUM_DUT  = 4,
    parameter  int CODE_W   = 4,
    parameter  int SETTLE_W = 8,
    localparam int SEL_W    = sel_width(NUM_DUT)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                abort,
    input  logic [SETTLE_W-1:0] settle_cycles,
    input  logic [NUM_DUT-1:0]  dut_mask,
    input  logic                cmp_in,
    output logic [SEL_W-1:0]    dut_sel,
    output logic                sw_en,
    output logic [CODE_W-1:0]   gate_code,
    output logic                busy,
    output logic                done,
    output logic                res_valid,
    output logic [SEL_W-1:0]    res_dut,
    output logic [CODE_W-1:0]   res_code,
    output logic                res_found
);

    localparam logic [CODE_W-1:0] CODE_MAX = CODE_W'(max_code(CODE_W));

    state_t              state;
    logic [SETTLE_W-1:0] settle_lat;
    logic [SETTLE_W-1:0] cnt;
    logic [NUM_DUT-1:0]  mask_lat;
    logic                cmp_s;
    logic                samp_last;
    logic                trip;
    logic                first_hit;
    logic [SEL_W-1:0]    first_idx;
    logic                next_hit;
    logic [SEL_W-1:0]    next_idx;

    raw_xtor_cmp_sync u_cmp_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (cmp_in),
        .q     (cmp_s)
    );

    // Descending scan so the lowest qualifying index is the one left standing.
    always_comb begin
        first_hit = 1'b0;
        first_idx = '0;
        next_hit  = 1'b0;
        next_idx  = '0;
        for (int i = NUM_DUT - 1; i >= 0; i--) begin
            if (dut_mask[i]) begin
                first_hit = 1'b1;
                first_idx = SEL_W'(i);
            end
            if (mask_lat[i] && (i > int'(dut_sel))) begin
                next_hit = 1'b1;
                next_idx = SEL_W'(i);
            end
        end
    end

`ifdef RAW_XTOR_MAJ3_EN
    logic [1:0] samp_cnt;
    logic [1:0] samp_hist;

    assign samp_last = (samp_cnt == 2'd2);
    assign trip      = (samp_hist[0] & samp_hist[1]) | (samp_hist[0] & cmp_s)
                     | (samp_hist[1] & cmp_s);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            samp_cnt  <= 2'd0;
            samp_hist <= 2'd0;
        end else if (state == ST_SAMPLE && !samp_last && !abort) begin
            samp_cnt  <= samp_cnt + 2'd1;
            samp_hist <= {samp_hist[0], cmp_s};
        end else begin
            samp_cnt  <= 2'd0;
        end
    end
`else
    assign samp_last = 1'b1;
    assign trip      = cmp_s;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            settle_lat <= '0;
            cnt        <= '0;
            mask_lat   <= '0;
            dut_sel    <= '0;
            sw_en      <= 1'b0;
            gate_code  <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            res_valid  <= 1'b0;
            res_dut    <= '0;
            res_code   <= '0;
            res_found  <= 1'b0;
        end else begin
            done      <= 1'b0;
            res_valid <= 1'b0;
            if (abort && state != ST_IDLE) begin
                state     <= ST_IDLE;
                sw_en     <= 1'b0;
                gate_code <= '0;
                busy      <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (start && !abort) begin
                            settle_lat <= settle_cycles;
                            mask_lat   <= dut_mask;
                            if (first_hit) begin
                                state     <= ST_SELECT;
                                busy      <= 1'b1;
                                dut_sel   <= first_idx;
                                sw_en     <= 1'b0;
                                gate_code <= '0;
                            end else begin
                                state <= ST_FINISH;
                            end
                        end
                    end
                    ST_SELECT: begin
                        state <= ST_SETTLE;
                        sw_en <= 1'b1;
                        cnt   <= settle_lat;
                    end
                    // A zero settle still spends one cycle here.
                    ST_SETTLE: begin
                        if (cnt <= SETTLE_W'(1)) state <= ST_SAMPLE;
                        else                     cnt   <= cnt - 1'b1;
                    end
                    ST_SAMPLE: begin
                        if (samp_last) begin
                            if (trip || gate_code == CODE_MAX) begin
                                state     <= ST_REPORT;
                                res_valid <= 1'b1;
                                res_dut   <= dut_sel;
                                res_code  <= gate_code;
                                res_found <= trip;
                                sw_en     <= 1'b0;
                                gate_code <= '0;
                            end else begin
                                state     <= ST_SETTLE;
                                gate_code <= gate_code + 1'b1;
                                cnt       <= settle_lat;
                            end
                        end
                    end
                    ST_REPORT: begin
                        if (next_hit) begin
                            state   <= ST_SELECT;
                            dut_sel <= next_idx;
                        end else begin
                            state <= ST_FINISH;
                            busy  <= 1'b0;
                        end
                    end
                    // done is registered out of FINISH, landing two cycles after start for an empty mask.
                    ST_FINISH: begin
                        state <= ST_IDLE;
                        done  <= 1'b1;
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule
